// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath width, register-file geometry and reset values.
package cpu_pkg;

  localparam int DATA_W    = 32;
  localparam int REG_N     = 32;
  localparam int REGADDR_W = 5;

  localparam logic [REGADDR_W-1:0] ZERO_REG = 5'd0;
  localparam logic [DATA_W-1:0]    DATA_RST = '0;

endpackage : cpu_pkg

// File: rtl/wb_mux.sv
// Write-back data select between the ALU result and the data-memory load value.
// Kept standalone so the forwarding unit can reuse the same selection.
module wb_mux
  import cpu_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic [DW-1:0] wd,
  input  logic [DW-1:0] memdata,
  input  logic          mem2r,
  output logic [DW-1:0] wbdata
);

  // Loads return memdata, everything else writes back the ALU result.
  always_comb begin
    wbdata = mem2r ? memdata : wd;
  end

endmodule : wb_mux

// File: rtl/wb_regfile.sv
// Write-back stage register file: commits MEM/WB results into a 32-entry GPR
// array, serves two combinational read ports with same-cycle write-through,
// and keeps a one-cycle record of the last committed write plus a counter.
module wb_regfile
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W,
  parameter int REG_N  = cpu_pkg::REG_N
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    wd,
  input  logic [DATA_W-1:0]    memdata,
  input  logic [REGADDR_W-1:0] rd,
  input  logic                 regw,
  input  logic                 mem2r,
  input  logic [REGADDR_W-1:0] ra1,
  input  logic [REGADDR_W-1:0] ra2,
  output logic [DATA_W-1:0]    rdata1,
  output logic [DATA_W-1:0]    rdata2,
  output logic                 last_valid,
  output logic [REGADDR_W-1:0] last_rd,
  output logic [DATA_W-1:0]    last_data,
  output logic [31:0]          wcount
);

  logic [DATA_W-1:0] regs [REG_N];
  logic [DATA_W-1:0] wbdata;
  logic              commit;
  logic [31:0]       wcount_q;

  wb_mux #(.DW(DATA_W)) u_wb_mux (
    .wd      (wd),
    .memdata (memdata),
    .mem2r   (mem2r),
    .wbdata  (wbdata)
  );

  // A write only counts when enabled, not aimed at r0, and not killed by reset.
  always_comb begin
    commit = regw && (rd != ZERO_REG) && !rst;
  end

  // Register array; reset wins over a simultaneous commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= DATA_RST;
      end
    end else if (commit) begin
      regs[rd] <= wbdata;
    end
  end

  // Read port 1: r0 reads zero, the in-flight commit bypasses the array.
  always_comb begin
    rdata1 = DATA_RST;
    if (!rst && (ra1 != ZERO_REG)) begin
      if (commit && (rd == ra1)) rdata1 = wbdata;
      else                       rdata1 = regs[ra1];
    end
  end

  // Read port 2: same rules as port 1, evaluated independently.
  always_comb begin
    rdata2 = DATA_RST;
    if (!rst && (ra2 != ZERO_REG)) begin
      if (commit && (rd == ra2)) rdata2 = wbdata;
      else                       rdata2 = regs[ra2];
    end
  end

  // Last-write record: valid pulses for one cycle, rd/data hold between commits.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_valid <= 1'b0;
      last_rd    <= ZERO_REG;
      last_data  <= DATA_RST;
    end else begin
      last_valid <= commit;
      if (commit) begin
        last_rd   <= rd;
        last_data <= wbdata;
      end
    end
  end

  // Committed-write counter, free-running modulo 2^32.
  always_ff @(posedge clk) begin
    if (rst)         wcount_q <= 32'd0;
    else if (commit) wcount_q <= wcount_q + 32'd1;
  end

  assign wcount = wcount_q;

endmodule : wb_regfile

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: the driver updates an architectural model
// and queues the expected outputs for each cycle; the monitor compares them.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst, regw, mem2r;
  logic [31:0] wd, memdata;
  logic [4:0]  rd, ra1, ra2;
  logic [31:0] rdata1, rdata2, last_data, wcount;
  logic        last_valid;
  logic [4:0]  last_rd;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .wd         (wd),
    .memdata    (memdata),
    .rd         (rd),
    .regw       (regw),
    .mem2r      (mem2r),
    .ra1        (ra1),
    .ra2        (ra2),
    .rdata1     (rdata1),
    .rdata2     (rdata2),
    .last_valid (last_valid),
    .last_rd    (last_rd),
    .last_data  (last_data),
    .wcount     (wcount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] r1;
    logic [31:0] r2;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic [31:0] wc;
  } exp_t;

  exp_t q[$];

  // Architectural model state
  logic [31:0] m_regs [32];
  logic        m_lv;
  logic [4:0]  m_lrd;
  logic [31:0] m_ld;
  logic [31:0] m_wcount;
  bit          armed;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // One MEM/WB entry per call: drive at negedge, advance the model, queue expectations.
  task automatic step(input logic r, input logic w, input logic [4:0] d, input logic m2r,
                      input logic [31:0] wdv, input logic [31:0] mdv,
                      input logic [4:0] a1, input logic [4:0] a2, input bit frc = 1'b0);
    exp_t        e;
    logic [31:0] wb;
    bit          c;
    @(negedge clk);
    rst = r; regw = w; rd = d; mem2r = m2r; wd = wdv; memdata = mdv; ra1 = a1; ra2 = a2;
    if (frc) begin
      force dut.wcount_q = 32'hFFFF_FFFF;
      m_wcount = 32'hFFFF_FFFF;
    end
    // Registered outputs during this cycle show the state before this edge.
    e.lv = m_lv; e.lrd = m_lrd; e.ld = m_ld; e.wc = m_wcount;
    wb = m2r ? mdv : wdv;
    c  = w && (d != 5'd0) && !r;
    if (r) begin
      foreach (m_regs[i]) m_regs[i] = 32'd0;
      m_lv = 1'b0; m_lrd = 5'd0; m_ld = 32'd0; m_wcount = 32'd0;
    end else begin
      if (c) begin
        m_regs[d] = wb;
        m_lrd     = d;
        m_ld      = wb;
        m_wcount  = m_wcount + 32'd1;
      end
      m_lv = c;
    end
    // A reader sees the newest architectural value, including this cycle's write.
    e.r1 = m_regs[a1];
    e.r2 = m_regs[a2];
    if (armed) q.push_back(e);
    if (frc) begin
      #1 release dut.wcount_q;
    end
  endtask

  // Monitor: outputs are sampled mid-low-phase, well clear of the posedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rdata1",     rdata1,            e.r1);
        check("rdata2",     rdata2,            e.r2);
        check("last_valid", {31'd0, last_valid}, {31'd0, e.lv});
        check("last_rd",    {27'd0, last_rd},  {27'd0, e.lrd});
        check("last_data",  last_data,         e.ld);
        check("wcount",     wcount,            e.wc);
      end
    end
  end

  initial begin
    logic [4:0] d, a1, a2;
    rst = 1'b1; regw = 1'b0; mem2r = 1'b0; wd = '0; memdata = '0; rd = '0; ra1 = '0; ra2 = '0;
    foreach (m_regs[i]) m_regs[i] = 32'd0;
    m_lv = 1'b0; m_lrd = '0; m_ld = '0; m_wcount = '0;
    armed = 1'b0;

    // First edge brings the DUT out of its unknown power-up state.
    step(1, 0, 0, 0, 0, 0, 0, 0);
    armed = 1'b1;
    step(1, 1, 4, 0, 32'h5555, 0, 4, 4);

    // All registers read zero after reset.
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 5'(i), 5'(31 - i));

    // Bypass on rd=5, then array read and last-write record.
    step(0, 1, 5, 0, 32'h1234_5678, 32'h0BAD_0BAD, 5, 0);
    step(0, 0, 0, 0, 0, 0, 5, 5);

    // memdata select, then a discarded r0 write.
    step(0, 1, 7, 1, 32'h0000_0001, 32'hDEAD_BEEF, 7, 5);
    step(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 0, 7);
    step(0, 0, 0, 1, 32'h7777, 32'h8888, 7, 0);

    // Reset beats a simultaneous commit.
    step(1, 1, 3, 0, 32'h0000_00AA, 0, 3, 5);
    step(0, 0, 0, 0, 0, 0, 3, 7);

    // Counter wrap from a preloaded all-ones value.
    step(0, 0, 0, 0, 0, 0, 1, 2, 1'b1);
    step(0, 1, 12, 0, 32'hCAFE_F00D, 0, 12, 1);
    step(0, 1, 13, 0, 32'h0000_0013, 0, 12, 13);

    // Back-to-back commits to one register.
    step(0, 1, 9, 0, 32'd1, 0, 9, 9);
    step(0, 1, 9, 0, 32'd2, 0, 9, 9);
    step(0, 1, 9, 1, 32'd9, 32'd3, 9, 9);
    step(0, 0, 0, 0, 0, 0, 9, 9);

    // Randomized traffic with addresses biased toward the write target.
    for (int n = 0; n < 400; n++) begin
      d  = 5'($urandom_range(0, 31));
      a1 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      a2 = ($urandom_range(0, 2) == 0) ? d : 5'($urandom_range(0, 31));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), d,
           1'($urandom_range(0, 1)), $urandom, $urandom, a1, a2);
    end

    // Dump the whole array at the end.
    for (int i = 0; i < 32; i++) step(0, 0, 0, 0, 0, 0, 5'(i), 5'(i ^ 5'h1F));

    armed = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    #3;
    check("queue_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_wb_regfile
